// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control block: FSM encoding,
// PC width, mul/div timeout default and the saturating counter helper.
package pipeline_ctrl_pkg;

    localparam int PC_WIDTH       = 32;
    localparam int MD_TIMEOUT_DEF = 63;
    localparam int TMO_W          = 6;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_LAUNCH = 2'd1,
        ST_MD_BUSY   = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags a decode-stage source that depends on a
// load still sitting in execute. Writes to x0 never create a dependency.
module hazard_detect (
    input  logic       d_valid_s,
    input  logic       d_use_rs1_s,
    input  logic       d_use_rs2_s,
    input  logic [4:0] d_rs1_idx_s,
    input  logic [4:0] d_rs2_idx_s,
    input  logic       e_valid_s,
    input  logic       e_load_s,
    input  logic [4:0] e_rd_idx_s,
    output logic       lu_s
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Source-operand match against the in-flight load destination
    always_comb begin
        rs1_hit_s = d_use_rs1_s & (d_rs1_idx_s == e_rd_idx_s);
        rs2_hit_s = d_use_rs2_s & (d_rs2_idx_s == e_rd_idx_s);
        lu_s      = e_valid_s & e_load_s & (e_rd_idx_s != 5'd0) & d_valid_s
                  & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: redirect/flush, load-use bubble, mul/div stall FSM with
// timeout watchdog, plus saturating stall and flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                D_valid_i,
    input  logic                D_use_rs1_i,
    input  logic                D_use_rs2_i,
    input  logic [4:0]          D_rs1_idx_i,
    input  logic [4:0]          D_rs2_idx_i,
    input  logic                E_valid_i,
    input  logic                E_load_i,
    input  logic                E_md_i,
    input  logic [4:0]          E_rd_idx_i,
    input  logic                E_jmp_sel_i,
    input  logic [PC_WIDTH-1:0] E_nPC_i,
    input  logic                md_done_i,
    output logic                F_stall_o,
    output logic                D_stall_o,
    output logic                E_stall_o,
    output logic                D_flush_o,
    output logic                E_flush_o,
    output logic                md_start_o,
    output logic                redirect_valid_o,
    output logic [PC_WIDTH-1:0] redirect_pc_o,
    output logic                md_err_o,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_cnt_o,
    output logic [1:0]          state_o
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MD_TIMEOUT);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [TMO_W-1:0]  tmo_r;
    logic [TMO_W-1:0]  tmo_nxt_s;
    logic              err_r;
    logic              err_set_s;
    logic [31:0]       stall_cnt_r;
    logic [31:0]       flush_cnt_r;

    logic              lu_s;
    logic              redirect_s;
    logic              md_req_s;
    logic              f_stall_s;
    logic              d_stall_s;
    logic              e_stall_s;
    logic              d_flush_s;
    logic              e_flush_s;
    logic              md_start_s;
    logic              redir_s;

    hazard_detect u_hazard_detect (
        .d_valid_s   (D_valid_i),
        .d_use_rs1_s (D_use_rs1_i),
        .d_use_rs2_s (D_use_rs2_i),
        .d_rs1_idx_s (D_rs1_idx_i),
        .d_rs2_idx_s (D_rs2_idx_i),
        .e_valid_s   (E_valid_i),
        .e_load_s    (E_load_i),
        .e_rd_idx_s  (E_rd_idx_i),
        .lu_s        (lu_s)
    );

    assign redirect_s = E_valid_i & E_jmp_sel_i;
    assign md_req_s   = E_valid_i & E_md_i;

    // Next-state and raw control decode; priority in RUN is redirect > md > load-use
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_r;
        err_set_s   = 1'b0;
        f_stall_s   = 1'b0;
        d_stall_s   = 1'b0;
        e_stall_s   = 1'b0;
        d_flush_s   = 1'b0;
        e_flush_s   = 1'b0;
        md_start_s  = 1'b0;
        redir_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    redir_s   = 1'b1;
                    d_flush_s = 1'b1;
                    e_flush_s = 1'b1;
                end else if (md_req_s) begin
                    f_stall_s   = 1'b1;
                    d_stall_s   = 1'b1;
                    e_stall_s   = 1'b1;
                    md_start_s  = 1'b1;
                    state_nxt_s = ST_MD_LAUNCH;
                end else if (lu_s) begin
                    f_stall_s = 1'b1;
                    d_stall_s = 1'b1;
                    e_flush_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MD_LAUNCH: begin
                f_stall_s   = 1'b1;
                d_stall_s   = 1'b1;
                e_stall_s   = 1'b1;
                tmo_nxt_s   = {TMO_W{1'b0}};
                state_nxt_s = ST_MD_BUSY;
            end
            ST_MD_BUSY: begin
                if (md_done_i) begin
                    state_nxt_s = ST_RUN;
                end else if (tmo_r == TMO_LIMIT) begin
                    // Watchdog expired: drop the operation and squash the md op in execute
                    err_set_s   = 1'b1;
                    e_flush_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    f_stall_s = 1'b1;
                    d_stall_s = 1'b1;
                    e_stall_s = 1'b1;
                    tmo_nxt_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign F_stall_o        = rst_n_i & f_stall_s;
    assign D_stall_o        = rst_n_i & d_stall_s;
    assign E_stall_o        = rst_n_i & e_stall_s;
    assign D_flush_o        = rst_n_i & d_flush_s;
    assign E_flush_o        = rst_n_i & e_flush_s;
    assign md_start_o       = rst_n_i & md_start_s;
    assign redirect_valid_o = rst_n_i & redir_s;
    assign redirect_pc_o    = redirect_valid_o ? E_nPC_i : {PC_WIDTH{1'b0}};
    assign md_err_o         = err_r;
    assign stall_cnt_o      = stall_cnt_r;
    assign flush_cnt_o      = flush_cnt_r;
    assign state_o          = state_r;

    // State, watchdog, sticky error and saturating perf counters
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_RUN;
            tmo_r       <= {TMO_W{1'b0}};
            err_r       <= 1'b0;
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            tmo_r       <= tmo_nxt_s;
            err_r       <= err_r | err_set_s;
            stall_cnt_r <= F_stall_o ? sat_inc32(stall_cnt_r) : stall_cnt_r;
            flush_cnt_r <= redirect_valid_o ? sat_inc32(flush_cnt_r) : flush_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a random run
// compared against a cycle-count reference model of the mul/div sequence.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int TMO = 63;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                d_valid, d_use1, d_use2;
    logic [4:0]          d_rs1, d_rs2, e_rd;
    logic                e_valid, e_load, e_md, e_jmp, md_done;
    logic [PC_WIDTH-1:0] e_npc;
    logic                f_stall, d_stall, e_stall, d_flush, e_flush, md_start;
    logic                rdr_valid, md_err;
    logic [PC_WIDTH-1:0] rdr_pc;
    logic [31:0]         stall_cnt, flush_cnt;
    logic [1:0]          state;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.MD_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .D_valid_i(d_valid), .D_use_rs1_i(d_use1), .D_use_rs2_i(d_use2),
        .D_rs1_idx_i(d_rs1), .D_rs2_idx_i(d_rs2),
        .E_valid_i(e_valid), .E_load_i(e_load), .E_md_i(e_md),
        .E_rd_idx_i(e_rd), .E_jmp_sel_i(e_jmp), .E_nPC_i(e_npc),
        .md_done_i(md_done),
        .F_stall_o(f_stall), .D_stall_o(d_stall), .E_stall_o(e_stall),
        .D_flush_o(d_flush), .E_flush_o(e_flush), .md_start_o(md_start),
        .redirect_valid_o(rdr_valid), .redirect_pc_o(rdr_pc),
        .md_err_o(md_err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .state_o(state)
    );

    task automatic set_idle();
        d_valid = 1'b0; d_use1 = 1'b0; d_use2 = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0;
        e_valid = 1'b0; e_load = 1'b0; e_md = 1'b0; e_rd = 5'd0; e_jmp = 1'b0;
        e_npc = '0; md_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        e_valid = 1'b1; e_jmp = 1'b1; e_md = 1'b1; e_load = 1'b1; e_rd = 5'd4;
        d_valid = 1'b1; d_use1 = 1'b1; d_rs1 = 5'd4; e_npc = 32'h44;
        #1;
        checks++;
        if ({f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid} !== 7'd0 || rdr_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b pc=%0h, expected 0000000 pc=0",
                     {f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid}, rdr_pc);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (state !== 2'd0 || md_err !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d err=%b stall=%0d flush=%0d, expected all 0",
                     state, md_err, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_load = 1'b1; e_rd = 5'd5; d_valid = 1'b1; d_use1 = 1'b1; d_rs1 = 5'd5;
        #1;
        checks++;
        if ({f_stall, d_stall, e_stall, e_flush, d_flush} !== 5'b11010) begin
            errors++;
            $display("FAIL load_use_rs1: got %b, expected 11010", {f_stall, d_stall, e_stall, e_flush, d_flush});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (f_stall !== 1'b0 || e_flush !== 1'b0 || stall_cnt !== 32'd1 || state !== 2'd0) begin
            errors++;
            $display("FAIL load_use_one_cycle: got stall=%b flush=%b cnt=%0d state=%0d, expected 0 0 1 0",
                     f_stall, e_flush, stall_cnt, state);
        end
        @(negedge clk);
        e_valid = 1'b1; e_load = 1'b1; e_rd = 5'd9; d_valid = 1'b1; d_use2 = 1'b1; d_rs2 = 5'd9; d_rs1 = 5'd2;
        #1;
        checks++;
        if ({f_stall, d_stall, e_flush} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_rs2: got %b, expected 111", {f_stall, d_stall, e_flush});
        end
    endtask

    task automatic test_x0();
        // rd, rs1, use1, e_valid, e_load per case; none may stall
        logic [4:0] rd_t  [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
        logic [4:0] rs_t  [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
        logic       use_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       ev_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       ld_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle();
            e_valid = ev_t[i]; e_load = ld_t[i]; e_rd = rd_t[i];
            d_valid = 1'b1; d_use1 = use_t[i]; d_rs1 = rs_t[i];
            #1;
            checks++;
            if ({f_stall, d_stall, e_flush} !== 3'b000) begin
                errors++;
                $display("FAIL no_hazard_case%0d: got %b, expected 000", i, {f_stall, d_stall, e_flush});
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_jmp = 1'b1; e_npc = 32'h80;
        #1;
        checks++;
        if ({rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall} !== 6'b111000 || rdr_pc !== 32'h80) begin
            errors++;
            $display("FAIL redirect: got %b pc=%0h, expected 111000 pc=80",
                     {rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall}, rdr_pc);
        end
        @(negedge clk);
        e_jmp = 1'b0;
        #1;
        checks++;
        if (rdr_valid !== 1'b0 || rdr_pc !== '0 || flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL redirect_after: got valid=%b pc=%0h cnt=%0d, expected 0 0 1", rdr_valid, rdr_pc, flush_cnt);
        end
    endtask

    task automatic test_md();
        int stall_cycles = 0;
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_md = 1'b1;
        #1;
        if (f_stall === 1'b1) stall_cycles++;
        checks++;
        if ({f_stall, d_stall, e_stall, md_start} !== 4'b1111 || state !== 2'd0) begin
            errors++;
            $display("FAIL md_launch: got %b state=%0d, expected 1111 state=0", {f_stall, d_stall, e_stall, md_start}, state);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            if (f_stall === 1'b1) stall_cycles++;
            checks++;
            if ({f_stall, d_stall, e_stall, md_start} !== 4'b1110 || state !== ((i == 1) ? 2'd1 : 2'd2)) begin
                errors++;
                $display("FAIL md_hold_%0d: got %b state=%0d, expected 1110 state=%0d",
                         i, {f_stall, d_stall, e_stall, md_start}, state, (i == 1) ? 1 : 2);
            end
        end
        @(negedge clk);
        md_done = 1'b1;
        #1;
        checks++;
        if ({f_stall, d_stall, e_stall, md_start} !== 4'b0000 || state !== 2'd2) begin
            errors++;
            $display("FAIL md_done: got %b state=%0d, expected 0000 state=2", {f_stall, d_stall, e_stall, md_start}, state);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 32'd6 || stall_cycles != 6) begin
            errors++;
            $display("FAIL md_total: got state=%0d cnt=%0d seen=%0d, expected 0 6 6", state, stall_cnt, stall_cycles);
        end
    endtask

    task automatic test_timeout();
        int busy = 0;
        bit found = 1'b0;
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_md = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            set_idle();
            #1;
            if (state === 2'd2 && f_stall === 1'b1) begin
                busy++;
            end else if (state === 2'd2) begin
                found = 1'b1;
                checks++;
                if (e_flush !== 1'b1 || d_flush !== 1'b0 || md_err !== 1'b0 || busy != TMO) begin
                    errors++;
                    $display("FAIL timeout_cycle: got eflush=%b dflush=%b err=%b busy=%0d, expected 1 0 0 %0d",
                             e_flush, d_flush, md_err, busy, TMO);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout_seen: got no timeout within 200 cycles, expected one after %0d", TMO);
        end
        @(negedge clk);
        #1;
        checks++;
        if (md_err !== 1'b1 || state !== 2'd0 || e_flush !== 1'b0 || stall_cnt !== 32'(TMO + 2)) begin
            errors++;
            $display("FAIL timeout_after: got err=%b state=%0d eflush=%b cnt=%0d, expected 1 0 0 %0d",
                     md_err, state, e_flush, stall_cnt, TMO + 2);
        end
    endtask

    task automatic test_priority();
        logic [PC_WIDTH-1:0] pc;
        pc = $urandom;
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_jmp = 1'b1; e_md = 1'b1; e_load = 1'b1; e_rd = 5'd3; e_npc = pc;
        d_valid = 1'b1; d_use1 = 1'b1; d_rs1 = 5'd3;
        #1;
        checks++;
        if ({rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall, md_start} !== 7'b1110000 || rdr_pc !== pc) begin
            errors++;
            $display("FAIL prio_redirect: got %b pc=%0h, expected 1110000 pc=%0h",
                     {rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall, md_start}, rdr_pc, pc);
        end
        @(negedge clk);
        e_jmp = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || {f_stall, d_stall, e_stall, md_start, e_flush} !== 5'b11110) begin
            errors++;
            $display("FAIL prio_md_over_lu: got state=%0d %b, expected 0 11110", state, {f_stall, d_stall, e_stall, md_start, e_flush});
        end
        @(negedge clk);
        e_jmp = 1'b1; md_done = 1'b1;
        #1;
        checks++;
        if (state !== 2'd1 || {rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall} !== 6'b000111) begin
            errors++;
            $display("FAIL launch_ignores: got state=%0d %b, expected 1 000111", state, {rdr_valid, d_flush, e_flush, f_stall, d_stall, e_stall});
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 2'd2 || {rdr_valid, e_flush, f_stall, d_stall, e_stall} !== 5'b00000) begin
            errors++;
            $display("FAIL busy_done: got state=%0d %b, expected 2 00000", state, {rdr_valid, e_flush, f_stall, d_stall, e_stall});
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (state !== 2'd0 || flush_cnt !== 32'd1 || md_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_end: got state=%0d flush=%0d err=%b, expected 0 1 0", state, flush_cnt, md_err);
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        @(negedge clk);
        e_valid = 1'b1; e_md = 1'b1;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL busy_reached: got state=%0d, expected 2", state);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid} !== 7'd0) begin
            errors++;
            $display("FAIL reset_busy_outputs: got %b, expected 0000000", {f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || md_start !== 1'b0 || f_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_after: got state=%0d stall=%0d flush=%0d start=%b fst=%b, expected all 0",
                     state, stall_cnt, flush_cnt, md_start, f_stall);
        end
    endtask

    task automatic test_random();
        // md_k: -1 when no mul/div is pending, otherwise cycles elapsed since the launch request
        int md_k = -1;
        int nk;
        bit rdr, mdq, lu, x_err = 1'b0;
        logic [2:0] x_st;
        logic x_df, x_ef, x_start, x_rv;
        logic [PC_WIDTH-1:0] x_pc;
        logic [1:0] x_state;
        longint x_scnt = 0, x_fcnt = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            e_valid = ($urandom_range(0, 3) != 0);
            e_load  = $urandom_range(0, 1);
            e_md    = ($urandom_range(0, 7) == 0);
            e_jmp   = ($urandom_range(0, 5) == 0);
            e_rd    = 5'($urandom_range(0, 3));
            e_npc   = $urandom;
            d_valid = $urandom_range(0, 1);
            d_use1  = $urandom_range(0, 1);
            d_use2  = $urandom_range(0, 1);
            d_rs1   = 5'($urandom_range(0, 3));
            d_rs2   = 5'($urandom_range(0, 3));
            md_done = ($urandom_range(0, 4) == 0);
            rdr = e_valid && e_jmp;
            mdq = e_valid && e_md;
            lu  = e_valid && e_load && e_rd != 0 && d_valid &&
                  ((d_use1 && d_rs1 == e_rd) || (d_use2 && d_rs2 == e_rd));
            x_st = 3'b000; x_df = 1'b0; x_ef = 1'b0; x_start = 1'b0; x_rv = 1'b0; x_pc = '0;
            nk = md_k;
            x_state = (md_k < 0) ? 2'd0 : ((md_k == 1) ? 2'd1 : 2'd2);
            if (md_k < 0) begin
                if (rdr) begin x_rv = 1'b1; x_df = 1'b1; x_ef = 1'b1; x_pc = e_npc; end
                else if (mdq) begin x_st = 3'b111; x_start = 1'b1; nk = 1; end
                else if (lu) begin x_st = 3'b110; x_ef = 1'b1; end
            end else if (md_k == 1) begin
                x_st = 3'b111; nk = 2;
            end else if (md_done) begin
                nk = -1;
            end else if (md_k - 2 == TMO) begin
                x_ef = 1'b1; nk = -1;
            end else begin
                x_st = 3'b111; nk = md_k + 1;
            end
            #1;
            checks++;
            if ({f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid} !== {x_st, x_df, x_ef, x_start, x_rv} ||
                rdr_pc !== x_pc) begin
                errors++;
                $display("FAIL rand_outputs cyc=%0d: got %b pc=%0h, expected %b pc=%0h", cyc,
                         {f_stall, d_stall, e_stall, d_flush, e_flush, md_start, rdr_valid}, rdr_pc,
                         {x_st, x_df, x_ef, x_start, x_rv}, x_pc);
            end
            checks++;
            if (state !== x_state || md_err !== x_err || stall_cnt !== 32'(x_scnt) || flush_cnt !== 32'(x_fcnt)) begin
                errors++;
                $display("FAIL rand_regs cyc=%0d: got state=%0d err=%b stall=%0d flush=%0d, expected %0d %b %0d %0d",
                         cyc, state, md_err, stall_cnt, flush_cnt, x_state, x_err, x_scnt, x_fcnt);
            end
            if (md_k >= 2 && !md_done && md_k - 2 == TMO) x_err = 1'b1;
            if (x_st[2]) x_scnt++;
            if (x_rv) x_fcnt++;
            md_k = nk;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_x0();
        test_redirect();
        test_md();
        test_timeout();
        test_priority();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
